// File: rtl/scan_fifo.sv
// scan_fifo: single-clock FIFO with a registered pop output and a full-scan chain
// over its control and output state.
// Optional build macro SCAN_MEM_EN: when defined, the storage array is appended to
// the scan chain after dout, and S0 comes from the last memory bit.
// Chain order (SI first): wr_ptr[0..AW-1], rd_ptr[0..AW-1], count[0..AW], pout,
// dout[0..WIDTH-1] [, mem[0][0..WIDTH-1] .. mem[DEPTH-1][WIDTH-1]] -> S0.
module scan_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pin,
  input  logic             sin,
  input  logic [WIDTH-1:0] din,
  output logic             pout,
  output logic [WIDTH-1:0] dout,
  input  logic             TM,
  input  logic             SI,
  output logic             S0
);

  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CtlLen = 3 * AW + 2 + WIDTH;
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pout_q, pout_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic              empty, full, pop_ok, push_ok;
  logic [CtlLen-1:0] ctl_chain, ctl_shift;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCount);
  // Both handshakes are gated off in scan mode so the memory cannot be written.
  assign pop_ok  = ~TM & sin & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept a push.
  assign push_ok = ~TM & pin & (~full | pop_ok);

  // Bit 0 of the chain sits next to SI; the MSB (dout[WIDTH-1]) drives the tail.
  assign ctl_chain = {dout_q, pout_q, count_q, rd_ptr_q, wr_ptr_q};
  assign ctl_shift = {ctl_chain[CtlLen-2:0], SI};

  // Next-state for control/output flops: shift in scan mode, FIFO update otherwise.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pout_d   = 1'b0;
    dout_d   = dout_q;
    if (TM) begin
      {dout_d, pout_d, count_d, rd_ptr_d, wr_ptr_d} = ctl_shift;
    end else begin
      pout_d = pop_ok;
      if (pop_ok) begin
        dout_d   = mem_q[rd_ptr_q];
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + (AW + 1)'(1);
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - (AW + 1)'(1);
      end
    end
  end

  // Control and output state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pout_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pout_q   <= pout_d;
      dout_q   <= dout_d;
    end
  end

  assign pout = pout_q;
  assign dout = dout_q;

`ifdef SCAN_MEM_EN
  localparam int unsigned MemLen = DEPTH * WIDTH;

  logic [MemLen-1:0] mem_chain, mem_shift;

  // Flatten the array so mem[0][0] follows dout[WIDTH-1] in the chain.
  always_comb begin
    mem_chain = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_chain[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

  assign mem_shift = {mem_chain[MemLen-2:0], dout_q[WIDTH-1]};
  assign S0        = mem_chain[MemLen-1];

  // Storage: shifts with the chain in scan mode, written on accepted pushes otherwise.
  always_ff @(posedge clock) begin
    if (TM) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_shift[i*WIDTH +: WIDTH];
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end
`else
  assign S0 = dout_q[WIDTH-1];

  // Storage: written on accepted pushes only; never reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end
`endif

endmodule

// File: tb/tb_scan_fifo.sv
// tb_scan_fifo: directed, table-driven bench for scan_fifo in its default build
// (WIDTH=9, DEPTH=8, memory outside the scan chain).
module tb_scan_fifo;

  logic       clock;
  logic       reset;
  logic       pin;
  logic       sin;
  logic [8:0] din;
  logic       pout;
  logic [8:0] dout;
  logic       TM;
  logic       SI;
  logic       S0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       p;
    logic       s;
    logic [8:0] d;
    logic       ep;
    logic [8:0] ed;
  } vec_t;

  vec_t vecs[$];

  scan_fifo dut (
    .clock (clock),
    .reset (reset),
    .pin   (pin),
    .sin   (sin),
    .din   (din),
    .pout  (pout),
    .dout  (dout),
    .TM    (TM),
    .SI    (SI),
    .S0    (S0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(logic p, logic s, logic [8:0] d, logic ep, logic [8:0] ed);
    vec_t v;
    v.p  = p;
    v.s  = s;
    v.d  = d;
    v.ep = ep;
    v.ed = ed;
    vecs.push_back(v);
  endfunction

  // Drive functional inputs on the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic p, input logic s, input logic [8:0] d);
    @(negedge clock);
    TM  = 1'b0;
    pin = p;
    sin = s;
    din = d;
    @(posedge clock);
    #1;
  endtask

  // One scan shift with pin/sin asserted and din all ones to expose any stray write.
  task automatic scan_step(input logic si);
    @(negedge clock);
    TM  = 1'b1;
    SI  = si;
    pin = 1'b1;
    sin = 1'b1;
    din = 9'h1FF;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic ep, input logic [8:0] ed);
    checks++;
    if (pout !== ep || dout !== ed) begin
      errors++;
      $display("FAIL %s: got pout=%0b dout=%03h, want pout=%0b dout=%03h",
               nm, pout, dout, ep, ed);
    end
  endtask

  task automatic check_s0(input string nm, input logic es);
    checks++;
    if (S0 !== es) begin
      errors++;
      $display("FAIL %s: got S0=%0b, want S0=%0b", nm, S0, es);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    TM    = 1'b0;
    pin   = 1'b0;
    sin   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] last;
    logic       pop_exp;
    int         drain_n;

    reset = 1'b1;
    pin   = 1'b0;
    sin   = 1'b0;
    din   = '0;
    TM    = 1'b0;
    SI    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 1'b0, 9'h000);
    check_s0("reset_s0", 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 9'(i), 1'b0, 9'h000);
    add(1'b1, 1'b0, 9'h1FF, 1'b0, 9'h000);
    for (int i = 1; i <= 8; i++) add(1'b0, 1'b1, 9'h000, 1'b1, 9'(i));
    add(1'b0, 1'b1, 9'h000, 1'b0, 9'h008);
    // Push+pop on empty: only the push lands.
    add(1'b1, 1'b1, 9'h0AA, 1'b0, 9'h008);
    add(1'b0, 1'b1, 9'h000, 1'b1, 9'h0AA);
    // Full, then push+pop together; a follow-up lone push must still be dropped.
    for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 9'h010 + 9'(i), 1'b0, 9'h0AA);
    add(1'b1, 1'b1, 9'h155, 1'b1, 9'h010);
    add(1'b1, 1'b0, 9'h0FF, 1'b0, 9'h010);
    for (int i = 1; i < 8; i++) add(1'b0, 1'b1, 9'h000, 1'b1, 9'h010 + 9'(i));
    add(1'b0, 1'b1, 9'h000, 1'b1, 9'h155);
    add(1'b0, 1'b1, 9'h000, 1'b0, 9'h155);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].p, vecs[i].s, vecs[i].d);
      check($sformatf("table[%0d]", i), vecs[i].ep, vecs[i].ed);
    end

    // Interleaved traffic across pointer wraps, checked against a queue model.
    last = 9'h155;
    for (int i = 0; i < 20; i++) begin
      pop_exp = ((i % 3) != 0) && (q.size() > 0);
      if (pop_exp) last = q.pop_front();
      q.push_back(9'h040 + 9'(i));
      drive(1'b1, (i % 3) != 0, 9'h040 + 9'(i));
      check($sformatf("wrap[%0d]", i), pop_exp, last);
    end
    drain_n = q.size();
    for (int k = 0; k < drain_n; k++) begin
      last = q.pop_front();
      drive(1'b0, 1'b1, 9'h000);
      check($sformatf("wrap_drain[%0d]", k), 1'b1, last);
    end
    drive(1'b0, 1'b1, 9'h000);
    check("wrap_empty", 1'b0, last);

    // Scan: preload memory, reset control state (memory survives), then shift.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 9'h060 + 9'(i));
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      scan_step(1'b1);
      check_s0($sformatf("scan_ones[%0d]", k), k == 20);
    end
    for (int k = 1; k <= 20; k++) begin
      scan_step(1'b0);
      check_s0($sformatf("scan_zeros[%0d]", k), k != 20);
    end
    // Shift in count=8 with both pointers at 0: only chain bit 9 (count[3]) is set.
    for (int j = 0; j < 20; j++) scan_step(j == 10);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 9'h000);
      check($sformatf("scan_mem[%0d]", i), 1'b1, 9'h060 + 9'(i));
    end
    drive(1'b0, 1'b1, 9'h000);
    check("scan_mem_empty", 1'b0, 9'h067);

    // Asynchronous reset in the middle of a cycle with count=5.
    do_reset();
    drive(1'b1, 1'b0, 9'h1A5);
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 9'h0B0 + 9'(i));
    drive(1'b0, 1'b1, 9'h000);
    check("pre_async_reset", 1'b1, 9'h1A5);
    check_s0("pre_async_reset_s0", 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 1'b0, 9'h000);
    check_s0("async_reset_s0", 1'b0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b1, 9'h000);
    check("post_reset_pop", 1'b0, 9'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
